vx_gfx_dcr_dispatch: RTL and testbench
======================================

# VX_gfx_dcr_dispatch

Parametrised DCR write dispatcher for the cluster graphics complex. It decodes each incoming DCR write against per-channel address windows and enqueues it into one small FIFO per matching graphics channel (raster, texture, OM, or future units). It replaces the fixed three-range, single-register DCR buffering with N configurable channels, per-channel queuing, backpressure and error reporting. It sits between the cluster DCR bus and the per-unit DCR inputs.

## Interface
Parameters:
- NUM_CHANNELS, 3: number of downstream graphics channels (1..16).
- ADDR_WIDTH, 12: DCR address width.
- DATA_WIDTH, 32: DCR data width.
- FIFO_DEPTH, 4: entries per channel FIFO (power of two, ≥2).
- RANGE_BEGIN, 0: flat NUM_CHANNELS*ADDR_WIDTH vector; slice i is channel i's inclusive window start.
- RANGE_END, 0: flat vector; slice i is channel i's exclusive window end.
- BCAST_BEGIN / BCAST_END, 0 / 0: broadcast window [begin, end), used only with GFX_DCR_BCAST_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset: logic resets on a rising edge where reset==0.
- in_valid  in  1  DCR write request.
- in_addr  in  ADDR_WIDTH  write address.
- in_data  in  DATA_WIDTH  write data.
- in_ready  out  1  write accepted when in_valid && in_ready.
- out_valid  out  NUM_CHANNELS  per-channel head valid.
- out_addr  out  NUM_CHANNELS*ADDR_WIDTH  per-channel head address.
- out_data  out  NUM_CHANNELS*DATA_WIDTH  per-channel head data.
- out_ready  in  NUM_CHANNELS  per-channel consumer ready.
- chan_pending  out  NUM_CHANNELS  FIFO i non-empty.
- idle  out  1  all FIFOs empty.
- err_unmapped  out  1  sticky: an accepted write matched no window.
- err_clear  in  1  clears err_unmapped.

## Operation
- Decode: match[i] = (in_addr >= RANGE_BEGIN[i]) && (in_addr < RANGE_END[i]); comparisons unsigned. Overlapping windows allowed; the write goes to every matching channel. A window with begin ≥ end never matches.
- Admission is all-or-nothing. in_ready = AND over matched i of !full[i]. Full is judged from the registered count only; there is no same-cycle pop bypass.
- Unmapped write (match == 0): in_ready=1. The write is consumed and discarded, and err_unmapped is set on the next edge.
- Enqueue: on in_valid && in_ready, {addr,data} is pushed into every matched FIFO in the same cycle. At most one write per cycle.
- Per-channel FIFO: circular buffer with wptr/rptr of log2(FIFO_DEPTH) bits that wrap naturally, and count of log2(FIFO_DEPTH)+1 bits. out_valid[i] = count[i] != 0. A pop occurs on out_valid[i] && out_ready[i]. Simultaneous push and pop leaves count unchanged.
- Ordering: FIFO order within each channel. There is no ordering between channels.
- err_unmapped: err_clear has priority over a same-cycle set; the result is cleared.
- Reset (reset==0 at an edge): all counts/pointers 0, out_valid=0, chan_pending=0, idle=1, err_unmapped=0. in_ready=0 while reset==0. Reset mid-operation discards all queued writes. FIFO storage contents are not reset; out_addr/out_data are don't-care while out_valid=0.

## Timing
- Latency: a write accepted at edge T into an empty FIFO shows out_valid=1 with its data after T (first cycle after the edge); there is no combinational in→out path.
- in_ready depends combinationally on in_addr and the registered counts only, never on out_ready.
- Throughput: 1 write/cycle per channel while its consumer is always ready, FIFO_DEPTH ≥ 2.
- chan_pending and idle are derived from the registered counts, so they are valid in the same cycle as out_valid.

## Configuration
- GFX_DCR_BCAST_EN defined: an address in [BCAST_BEGIN, BCAST_END) forces match = all ones, OR'd with the window decode. The write is admitted only when every FIFO has space, and it is never unmapped.
- Undefined: the BCAST parameters are ignored. Broadcast addresses decode through the channel windows only and are unmapped if no window matches.

## Test plan
- NUM_CHANNELS=3, windows [0x100,0x110),[0x200,0x220),[0x300,0x304): write 0x105/0xAA → out_valid=3'b001 the next cycle, out_addr[0]=0x105, out_data[0]=0xAA; channels 1 and 2 stay idle.
- Hold out_ready[1]=0 and send 5 writes to 0x200..0x204 with FIFO_DEPTH=4: the first 4 are accepted and in_ready=0 on the 5th. Raise out_ready[1]: entries drain in order 0x200..0x203, and the 5th is accepted on the cycle after the first pop.
- Write to 0x050 (unmapped): accepted in one cycle, no out_valid, err_unmapped=1 on the next cycle. err_clear pulse → 0. err_clear asserted together with a new unmapped write → result 0.
- Overlapping windows ch0=[0x100,0x200), ch1=[0x180,0x280) with ch1 full: a write to 0x190 stalls and is not enqueued into ch0. Once ch1 pops, it enters both channels in the same cycle.
- With GFX_DCR_BCAST_EN, BCAST=[0x400,0x401): write 0x400/0x1 → all three out_valid=1 the next cycle. Without the macro → err_unmapped=1.
- Fill ch0 with 3 entries, then assert reset=0 for one edge: idle=1, out_valid=0, and in_ready=0 during reset. Release reset: a new write appears alone at the ch0 head.

Source files
------------

// File: rtl/vx_gfx_dcr_dispatch.sv
// DCR write dispatcher for the cluster graphics complex.
// Each incoming DCR write is decoded against per-channel address windows and
// pushed into a small FIFO for every channel whose window it hits. Admission
// is all-or-nothing across the matched channels. Writes that hit no window are
// consumed and flagged through the sticky err_unmapped bit.
// Optional feature: define GFX_DCR_BCAST_EN to enable the broadcast window
// [BCAST_BEGIN, BCAST_END), which targets every channel.
module vx_gfx_dcr_dispatch #(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] RANGE_BEGIN = '0,
  parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] RANGE_END   = '0,
  parameter logic [ADDR_WIDTH-1:0] BCAST_BEGIN = '0,
  parameter logic [ADDR_WIDTH-1:0] BCAST_END   = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [ADDR_WIDTH-1:0]              in_addr,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               in_ready,
  output logic [NUM_CHANNELS-1:0]            out_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] out_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_CHANNELS-1:0]            out_ready,
  output logic [NUM_CHANNELS-1:0]            chan_pending,
  output logic                               idle,
  output logic                               err_unmapped,
  input  logic                               err_clear
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef GFX_DCR_BCAST_EN
  localparam logic BCAST_ON = 1'b1;
`else
  // Broadcast window exists in the decode but is masked off in this build.
  localparam logic BCAST_ON = 1'b0;
`endif

  logic [NUM_CHANNELS-1:0] win_match;
  logic [NUM_CHANNELS-1:0] match;
  logic [NUM_CHANNELS-1:0] full;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic                    bcast_hit;
  logic                    accept;

  logic [CNT_W-1:0]   count [NUM_CHANNELS];
  logic [PTR_W-1:0]   wptr  [NUM_CHANNELS];
  logic [PTR_W-1:0]   rptr  [NUM_CHANNELS];
  logic [ENTRY_W-1:0] mem   [NUM_CHANNELS][FIFO_DEPTH];

  // Address decode: unsigned window compare per channel, plus broadcast.
  always_comb begin
    win_match = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      win_match[i] = (in_addr >= RANGE_BEGIN[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                     (in_addr <  RANGE_END[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    bcast_hit = (in_addr >= BCAST_BEGIN) && (in_addr < BCAST_END);
    match     = win_match | {NUM_CHANNELS{bcast_hit & BCAST_ON}};
  end

  // Admission: every matched FIFO must have room, judged from registered counts.
  always_comb begin
    in_ready = reset;
    full     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      full[i] = (count[i] == FULL_CNT);
      if (match[i] && full[i]) in_ready = 1'b0;
    end
    accept = in_valid && in_ready;
    push   = {NUM_CHANNELS{accept}} & match;
    pop    = out_valid & out_ready;
  end

  // FIFO control: pointers wrap naturally, push+pop together keeps count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count[i] <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // FIFO storage: data only, never reset; push is already gated by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (push[i]) mem[i][wptr[i]] <= {in_addr, in_data};
    end
  end

  // Head presentation and status, all from registered state.
  always_comb begin
    out_valid = '0;
    out_addr  = '0;
    out_data  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      out_valid[i] = (count[i] != '0);
      {out_addr[i*ADDR_WIDTH +: ADDR_WIDTH], out_data[i*DATA_WIDTH +: DATA_WIDTH]} = mem[i][rptr[i]];
    end
    chan_pending = out_valid;
    idle         = ~|out_valid;
  end

  // Sticky unmapped-write flag; clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_unmapped <= 1'b0;
    end else if (err_clear) begin
      err_unmapped <= 1'b0;
    end else if (accept && (match == '0)) begin
      err_unmapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_gfx_dcr_dispatch.sv
// Self-checking bench for vx_gfx_dcr_dispatch: scoreboard of per-channel
// expected queues plus directed checks, and a second instance with
// overlapping windows.
module tb_vx_gfx_dcr_dispatch;

  localparam int NC = 3, AW = 12, DW = 32, DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic              in_valid = 1'b0;
  logic [AW-1:0]     in_addr = '0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic [NC-1:0]     out_valid;
  logic [NC*AW-1:0]  out_addr;
  logic [NC*DW-1:0]  out_data;
  logic [NC-1:0]     out_ready = '1;
  logic [NC-1:0]     chan_pending;
  logic              idle;
  logic              err_unmapped;
  logic              err_clear = 1'b0;

  vx_gfx_dcr_dispatch #(
    .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .RANGE_BEGIN({12'h300, 12'h200, 12'h100}),
    .RANGE_END  ({12'h304, 12'h220, 12'h110}),
    .BCAST_BEGIN(12'h400), .BCAST_END(12'h401)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .chan_pending(chan_pending), .idle(idle),
    .err_unmapped(err_unmapped), .err_clear(err_clear)
  );

  // Overlapping-window instance
  logic            o_in_valid = 1'b0;
  logic [AW-1:0]   o_in_addr = '0;
  logic [DW-1:0]   o_in_data = '0;
  logic            o_in_ready;
  logic [1:0]      o_out_valid;
  logic [2*AW-1:0] o_out_addr;
  logic [2*DW-1:0] o_out_data;
  logic [1:0]      o_out_ready = 2'b00;
  logic [1:0]      o_pending;
  logic            o_idle;
  logic            o_err;
  logic            o_err_clear = 1'b0;

  vx_gfx_dcr_dispatch #(
    .NUM_CHANNELS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .RANGE_BEGIN({12'h180, 12'h100}),
    .RANGE_END  ({12'h280, 12'h200}),
    .BCAST_BEGIN(12'h000), .BCAST_END(12'h000)
  ) u_ovl (
    .clk(clk), .reset(reset),
    .in_valid(o_in_valid), .in_addr(o_in_addr), .in_data(o_in_data), .in_ready(o_in_ready),
    .out_valid(o_out_valid), .out_addr(o_out_addr), .out_data(o_out_data), .out_ready(o_out_ready),
    .chan_pending(o_pending), .idle(o_idle),
    .err_unmapped(o_err), .err_clear(o_err_clear)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode of the main instance's windows.
  function automatic logic [NC-1:0] decode(input logic [AW-1:0] a);
    logic [NC-1:0] m;
    m[0] = (a >= 12'h100) && (a < 12'h110);
    m[1] = (a >= 12'h200) && (a < 12'h220);
    m[2] = (a >= 12'h300) && (a < 12'h304);
`ifdef GFX_DCR_BCAST_EN
    if (a == 12'h400) m = '1;
`endif
    return m;
  endfunction

  // Scoreboard state: expected FIFO contents and error flag.
  logic [AW+DW-1:0] exq [NC][$];
  logic             err_m = 1'b0;
  bit               mon_en = 1'b0;
  bit               acc_flag = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [NC-1:0] m;
      logic [NC-1:0] vexp;
      logic          rdy;
      m   = decode(in_addr);
      rdy = reset;
      for (int i = 0; i < NC; i++) begin
        if (m[i] && exq[i].size() >= DEPTH) rdy = 1'b0;
        vexp[i] = (exq[i].size() != 0);
      end
      check("out_valid", out_valid, vexp);
      check("chan_pending", chan_pending, vexp);
      check("idle", idle, vexp == '0);
      check("err_unmapped", err_unmapped, err_m);
      check("in_ready", in_ready, rdy);
      for (int i = 0; i < NC; i++) begin
        if (vexp[i]) check($sformatf("head%0d", i), {out_addr[i*AW +: AW], out_data[i*DW +: DW]}, exq[i][0]);
      end
      acc_flag = in_valid && in_ready && reset;
      if (!reset) begin
        for (int i = 0; i < NC; i++) exq[i].delete();
        err_m = 1'b0;
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (vexp[i] && out_ready[i]) void'(exq[i].pop_front());
        end
        if (in_valid && rdy) begin
          for (int i = 0; i < NC; i++) if (m[i]) exq[i].push_back({in_addr, in_data});
        end
        if (err_clear) err_m = 1'b0;
        else if (in_valid && rdy && m == '0) err_m = 1'b1;
      end
    end
  end

  task automatic wait_acc(input int max);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_flag && n < max);
    if (!acc_flag) check("accept_timeout", 64'd0, 64'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    wait_acc(20);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = '1;
    while (!idle && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_idle", idle, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_idle", idle, 64'd1);
    check("rst_valid", out_valid, 64'd0);
    check("rst_err", err_unmapped, 64'd0);
    check("rst_in_ready", in_ready, 64'd0);
    reset = 1'b1;

    // Single write to channel 0
    wr(12'h105, 32'hAA);
    check("t1_valid", out_valid, 64'h1);
    check("t1_pending", chan_pending, 64'h1);
    check("t1_addr", out_addr[AW-1:0], 64'h105);
    check("t1_data", out_data[DW-1:0], 64'hAA);
    drain();

    // Backpressure on channel 1
    out_ready = 3'b101;
    for (int k = 0; k < 4; k++) wr(12'h200 + AW'(k), 32'h1000 + k);
    in_valid = 1'b1;
    in_addr  = 12'h204;
    in_data  = 32'h1004;
    #1;
    check("bp_stall0", in_ready, 64'd0);
    @(posedge clk);
    #1;
    check("bp_stall1", in_ready, 64'd0);
    check("bp_head", out_addr[2*AW-1:AW], 64'h200);
    out_ready = 3'b111;
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", in_ready, 64'd1);
    @(posedge clk);
    check("bp_accept5", acc_flag, 64'd1);
    #1 in_valid = 1'b0;
    drain();

    // Unmapped writes and error clear
    wr(12'h050, 32'h11);
    check("unm_err", err_unmapped, 64'd1);
    check("unm_valid", out_valid, 64'd0);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("unm_clear", err_unmapped, 64'd0);
    wr(12'h060, 32'h22);
    check("unm_err2", err_unmapped, 64'd1);
    err_clear = 1'b1;
    wr(12'h070, 32'h33);
    err_clear = 1'b0;
    check("unm_clear_prio", err_unmapped, 64'd0);

    // Broadcast address
    wr(12'h400, 32'h1);
`ifdef GFX_DCR_BCAST_EN
    check("bcast_valid", out_valid, 64'h7);
    check("bcast_err", err_unmapped, 64'd0);
`else
    check("bcast_valid", out_valid, 64'h0);
    check("bcast_err", err_unmapped, 64'd1);
`endif
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    drain();

    // Window boundaries
    wr(12'h10F, 32'h5);
    check("bnd_10f", out_valid, 64'h1);
    wr(12'h303, 32'h6);
    check("bnd_303", out_valid, 64'h4);
    wr(12'h304, 32'h7);
    check("bnd_304_err", err_unmapped, 64'd1);
    wr(12'h110, 32'h8);
    check("bnd_110_valid", out_valid, 64'h0);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    drain();

    // Reset mid-operation discards queued writes
    out_ready = 3'b000;
    wr(12'h100, 32'hA0);
    wr(12'h101, 32'hA1);
    wr(12'h102, 32'hA2);
    check("rm_filled", out_valid, 64'h1);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_addr  = 12'h100;
    #1;
    check("rm_in_ready", in_ready, 64'd0);
    @(posedge clk);
    #1;
    check("rm_idle", idle, 64'd1);
    check("rm_valid", out_valid, 64'd0);
    check("rm_in_ready2", in_ready, 64'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    wr(12'h10A, 32'h55);
    check("rm_new_valid", out_valid, 64'h1);
    check("rm_new_addr", out_addr[AW-1:0], 64'h10A);
    check("rm_new_data", out_data[DW-1:0], 64'h55);
    drain();

    // Overlapping windows with channel 1 full
    o_in_valid = 1'b1;
    o_in_addr  = 12'h250;
    for (int k = 0; k < 4; k++) begin
      o_in_data = k;
      @(posedge clk);
      #1;
    end
    o_in_addr = 12'h190;
    o_in_data = 32'h99;
    #1;
    check("ovl_stall", o_in_ready, 64'd0);
    @(posedge clk);
    #1;
    check("ovl_ch0_empty", o_out_valid, 64'h2);
    check("ovl_stall2", o_in_ready, 64'd0);
    o_out_ready = 2'b10;
    @(posedge clk);
    #1 o_out_ready = 2'b00;
    check("ovl_ready", o_in_ready, 64'd1);
    check("ovl_ch1_head", o_out_data[2*DW-1:DW], 64'd1);
    @(posedge clk);
    #1 o_in_valid = 1'b0;
    check("ovl_both", o_out_valid, 64'h3);
    check("ovl_ch0_addr", o_out_addr[AW-1:0], 64'h190);
    check("ovl_ch0_data", o_out_data[DW-1:0], 64'h99);
    check("ovl_ch1_full", o_in_ready, 64'd0);
    o_out_ready = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    check("ovl_idle", o_idle, 64'd1);
    check("ovl_err", o_err, 64'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
